// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue
// Instruction fetch front end between the decode side and inst_rom. Owns the
// fetch PC, drives the ROM address/chip-enable and buffers fetched {pc, inst}
// pairs in a small prefetch FIFO so fetch runs ahead while decode is stalled.
// A taken branch empties the queue and redirects fetch.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   rom_addr_o       instruction address to inst_rom
//   rom_ce_o         ROM chip enable; a fetch happens every cycle it is 1
//   rom_data_i       instruction from inst_rom, combinational on rom_addr_o
//   if_valid_o       queue head is valid
//   if_pc_o          PC of the queue head (0 when empty)
//   if_inst_o        instruction of the queue head (0 when empty)
//   if_ready_i       consumer accepts the head this cycle
//   branch_flag_i    taken branch / redirect, one-cycle pulse
//   branch_target_i  redirect address, low two bits ignored
module inst_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] rom_addr_o,
   output logic        rom_ce_o,
   input  logic [31:0] rom_data_i,
   output logic        if_valid_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   input  logic        if_ready_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]   r_fetch_pc;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [31:0]   r_pc_mem   [DEPTH];
   logic [31:0]   r_inst_mem [DEPTH];

   logic          w_empty;
   logic          w_full;
   logic          w_pop;
   logic          w_fetch;
   logic [31:0]   w_target;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CW'(DEPTH));
   // Masking with the full word keeps every target bit in use while forcing
   // word alignment.
   assign w_target = branch_target_i & ~32'h0000_0003;

   // Outputs are forced to zero during reset, even though the registers only
   // clear on the edge.
   assign if_valid_o = ~rst & ~w_empty & ~branch_flag_i;
   assign w_pop      = if_valid_o & if_ready_i;
   // A pop frees the slot in the same cycle, so a full queue still fetches.
   assign w_fetch    = ~rst & ~branch_flag_i & (~w_full | w_pop);

   assign rom_ce_o   = w_fetch;
   assign rom_addr_o = rst ? 32'h0 : r_fetch_pc;
   assign if_pc_o    = (rst | w_empty) ? 32'h0 : r_pc_mem[r_rd_ptr];
   assign if_inst_o  = (rst | w_empty) ? 32'h0 : r_inst_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fetch_pc <= RESET_PC;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_pc_mem[i]   <= 32'h0;
            r_inst_mem[i] <= 32'h0;
         end
      end else if (branch_flag_i) begin
         r_fetch_pc <= w_target;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
      end else begin
         if (w_fetch) begin
            r_pc_mem[r_wr_ptr]   <= r_fetch_pc;
            r_inst_mem[r_wr_ptr] <= rom_data_i;
            r_wr_ptr             <= r_wr_ptr + PW'(1);
            r_fetch_pc           <= r_fetch_pc + 32'd4;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_fetch, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_inst_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rom_addr_o;
   logic        rom_ce_o;
   logic [31:0] rom_data_i;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_ready_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_q [$];
   logic [31:0] m_fpc;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign rom_data_i = rom_word(rom_addr_o);

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .rst             (rst),
      .rom_addr_o      (rom_addr_o),
      .rom_ce_o        (rom_ce_o),
      .rom_data_i      (rom_data_i),
      .if_valid_o      (if_valid_o),
      .if_pc_o         (if_pc_o),
      .if_inst_o       (if_inst_o),
      .if_ready_i      (if_ready_i),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: drive inputs at the falling edge, compare the combinational
   // outputs against the model, then advance the model across the rising edge.
   task automatic cyc(input logic r, input logic rdy, input logic br, input logic [31:0] tgt);
      logic        e_ce, e_valid, pop, fetch;
      logic [31:0] e_addr, e_pc, e_inst;
      int          n;
      rst = r; if_ready_i = rdy; branch_flag_i = br; branch_target_i = tgt;
      #1;
      n = m_q.size();
      if (r) begin
         e_ce = 0; e_addr = 0; e_valid = 0; e_pc = 0; e_inst = 0;
      end else begin
         e_valid = (n > 0) && !br;
         pop     = e_valid && rdy;
         e_ce    = !br && ((n < DEPTH) || pop);
         e_addr  = m_fpc;
         e_pc    = (n > 0) ? m_q[0] : 32'h0;
         e_inst  = (n > 0) ? rom_word(m_q[0]) : 32'h0;
      end
      chk("rom_ce",   {31'b0, rom_ce_o},   {31'b0, e_ce});
      chk("rom_addr", rom_addr_o,          e_addr);
      chk("if_valid", {31'b0, if_valid_o}, {31'b0, e_valid});
      chk("if_pc",    if_pc_o,             e_pc);
      chk("if_inst",  if_inst_o,           e_inst);
      if (r) begin
         m_q.delete();
         m_fpc = RESET_PC;
      end else if (br) begin
         m_q.delete();
         m_fpc = {tgt[31:2], 2'b00};
      end else begin
         pop   = (n > 0) && rdy;
         fetch = (n < DEPTH) || pop;
         if (pop)   void'(m_q.pop_front());
         if (fetch) begin
            m_q.push_back(m_fpc);
            m_fpc = m_fpc + 32'd4;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1; if_ready_i = 0; branch_flag_i = 0; branch_target_i = 0;
      m_fpc = RESET_PC;
      @(negedge clk);

      // Reset then stream with ready held high.
      cyc(1, 0, 0, 0);
      cyc(1, 1, 0, 0);
      repeat (6) cyc(0, 1, 0, 0);

      // Fill from reset with ready low, one-cycle pop while full, then drain.
      cyc(1, 0, 0, 0);
      repeat (6) cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      repeat (2) cyc(0, 0, 0, 0);
      repeat (6) cyc(0, 1, 0, 0);

      // Redirect with three entries queued; target low bits dropped.
      cyc(1, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 32'h0000_0043);
      repeat (4) cyc(0, 1, 0, 0);

      // Redirect near the top of the address space to exercise wrap.
      cyc(0, 1, 1, 32'hFFFF_FFF8);
      repeat (6) cyc(0, 1, 0, 0);

      // Back-to-back redirects: the last one wins.
      cyc(0, 1, 1, 32'h0000_1000);
      cyc(0, 1, 1, 32'h0000_2002);
      repeat (3) cyc(0, 1, 0, 0);

      // Reset with the queue full discards everything.
      repeat (6) cyc(0, 0, 0, 0);
      cyc(1, 0, 0, 0);
      repeat (4) cyc(0, 1, 0, 0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         logic        r, rdy, br;
         logic [31:0] tgt;
         r   = ($urandom_range(0, 99) == 0);
         rdy = ($urandom_range(0, 3) != 0);
         br  = ($urandom_range(0, 12) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         cyc(r, rdy, br, tgt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction fetch front end placed between the openmips core's decode side and inst_rom. It owns the fetch PC and drives the ROM address and chip-enable. Each fetched {pc, inst} pair goes into a small prefetch FIFO, so ROM fetch continues while decode is stalled. Taken branches flush the queue and redirect fetch.

Parameters:
DEPTH, 4, prefetch FIFO entries; power of 2, at least 2
RESET_PC, 32'h0000_0000, first fetch address after reset; word-aligned

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous active-high reset
rom_addr_o  output  32  instruction address to inst_rom (InstAddrBus)
rom_ce_o  output  1  ROM chip enable; a fetch occurs in every cycle this is 1
rom_data_i  input  32  instruction from inst_rom (InstBus); combinational, valid in the same cycle as the address
if_valid_o  output  1  queue head is valid
if_pc_o  output  32  PC of the queue head
if_inst_o  output  32  instruction of the queue head
if_ready_i  input  1  consumer accepts the head this cycle (deasserted on stall)
branch_flag_i  input  1  taken branch/redirect, one-cycle pulse
branch_target_i  input  32  redirect address; bits [1:0] are ignored and treated as 00

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc <= RESET_PC; count, rd_ptr and wr_ptr <= 0; all FIFO entries <= 0.
  - While rst=1: rom_ce_o=0, rom_addr_o=0, if_valid_o=0, if_pc_o=0, if_inst_o=0.
  - Reset asserted mid-operation discards all queued entries and any pending redirect in the same edge.
- rom_addr_o = fetch_pc, combinational from the register.
- pop = if_valid_o & if_ready_i.
- fetch = ~rst & ~branch_flag_i & (count<DEPTH | pop). rom_ce_o = fetch.
- On fetch:
  - Push {fetch_pc, rom_data_i} at wr_ptr.
  - fetch_pc <= fetch_pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
- If no fetch and no branch, fetch_pc holds.
- Full with a simultaneous pop: push and pop occur in the same cycle; count is unchanged.
- Full without pop: rom_ce_o=0; address and pointers hold.
- Output side:
  - if_valid_o = (count!=0) & ~branch_flag_i.
  - if_pc_o and if_inst_o are the head entry, read from registered storage. They show 0 when count==0.
- Count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Empty: no pop possible, so if_ready_i is ignored.
- Latency: an instruction is fetched in cycle N and presented at the output in cycle N+1 at the earliest. The first fetch is the first cycle after rst deasserts; if_valid_o first rises one cycle later.
- Steady state with if_ready_i held at 1: count settles at 1, with one instruction accepted per cycle.
- Redirect (branch_flag_i=1):
  - Highest priority after rst.
  - That cycle: no push, no pop, rom_ce_o=0, if_valid_o=0.
  - Next edge: count, rd_ptr and wr_ptr <= 0; fetch_pc <= {branch_target_i[31:2], 2'b00}.
  - Next cycle: the fetch at the target starts if branch_flag_i is low.
  - Back-to-back redirects: the last one wins.
- No internal state machine beyond pointer/count logic. Pointer width is log2(DEPTH); pointers wrap naturally. Count width is log2(DEPTH)+1.

Test Plan:
- Reset, then release with if_ready_i=1 -> cycle 1: rom_ce_o=1, rom_addr_o=0. Cycle 2: if_valid_o=1, if_pc_o=0, if_inst_o=ROM[0]. Consecutive PCs 0,4,8 are then presented one per cycle.
- if_ready_i=0 from reset -> four fetches at 0,4,8,C. rom_ce_o then drops with rom_addr_o held at 0x10. Raise if_ready_i -> heads 0,4,8,C,10 in order with no gap, count stays at 4.
- Queue full, if_ready_i=1 for one cycle -> pop of PC 0 and push of PC 0x10 in the same cycle; count stays 4; next head is PC 4.
- With 3 entries queued, pulse branch_flag_i with target 0x0000_0043 -> that cycle if_valid_o=0 and rom_ce_o=0. Next cycle rom_addr_o=0x40 and the queue is empty. The following cycle the head is PC 0x40 with ROM[0x40]; stale entries never appear.
- Redirect to 0xFFFF_FFF8 with if_ready_i=1 -> presented PCs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- rst asserted with the queue full -> the next cycle has all outputs 0. After release, fetch restarts at RESET_PC and the old entries are never presented.
